// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike rate decoder: valid/ready handshake plus the
// per-window measurement word and the overrun pulse.
interface spike_rate_decoder_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ISI_W = 16
) ();

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [ISI_W-1:0] out_isi;
  logic             out_sat;
  logic             overrun;

  // Producer side (the decoder)
  modport master (
    output out_valid,
    output out_count,
    output out_isi,
    output out_sat,
    output overrun,
    input  out_ready
  );

  // Consumer side (host / readout bus)
  modport slave (
    input  out_valid,
    input  out_count,
    input  out_isi,
    input  out_sat,
    input  overrun,
    output out_ready
  );

endinterface

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts rising edges of a spike line over back-to-back
// windows, tracks the most recent inter-spike interval, and emits one result
// word per window over a valid/ready channel. An unaccepted result is
// replaced by a newer one and flagged with a one-cycle overrun pulse.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_W = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ISI_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spike_in,
  input  logic                en,
  input  logic [WINDOW_W-1:0] window_len,
  spike_rate_decoder_if.master res
);

  localparam logic [CNT_W-1:0]    CntMax = '1;
  localparam logic [ISI_W-1:0]    IsiMax = '1;
  localparam logic [WINDOW_W-1:0] RemOne = WINDOW_W'(1);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e              state_q, state_d;
  logic                prev_q;
  logic [WINDOW_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [ISI_W-1:0]    isi_cnt_q, isi_cnt_d;
  logic [ISI_W-1:0]    last_isi_q, last_isi_d;
  logic                seen_q, seen_d;

  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic [ISI_W-1:0]    out_isi_q, out_isi_d;
  logic                out_sat_q, out_sat_d;
  logic                overrun_q, overrun_d;

  logic                evt;
  logic [WINDOW_W-1:0] win_len_eff;
  logic [CNT_W-1:0]    cnt_upd;
  logic                sat_upd;
  logic [ISI_W-1:0]    isi_cnt_upd;
  logic [ISI_W-1:0]    last_isi_upd;
  logic                seen_upd;
  logic                load;

  // A held-high line only produces one event, on its rising edge.
  assign evt         = spike_in & ~prev_q;
  assign win_len_eff = (window_len == '0) ? RemOne : window_len;

  // Per-cycle counter updates for a COUNT cycle, before any window-end reload.
  always_comb begin
    cnt_upd      = cnt_q;
    sat_upd      = sat_q;
    isi_cnt_upd  = (isi_cnt_q == IsiMax) ? IsiMax : isi_cnt_q + ISI_W'(1);
    last_isi_upd = last_isi_q;
    seen_upd     = seen_q;
    if (evt) begin
      if (cnt_q == CntMax) begin
        sat_upd = 1'b1;
      end else begin
        cnt_upd = cnt_q + CNT_W'(1);
      end
      // The interval includes the event cycle itself, hence the +1.
      if (seen_q) begin
        last_isi_upd = (isi_cnt_q == IsiMax) ? IsiMax : isi_cnt_q + ISI_W'(1);
      end
      isi_cnt_upd = '0;
      seen_upd    = 1'b1;
    end
  end

  // Window FSM: next state, window counters and result load strobe.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    isi_cnt_d  = isi_cnt_q;
    last_isi_d = last_isi_q;
    seen_d     = seen_q;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        isi_cnt_d  = '0;
        last_isi_d = '0;
        seen_d     = 1'b0;
        if (en) begin
          rem_d   = win_len_eff;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = StCount;
        end
      end
      StCount: begin
        if (!en && (rem_q != RemOne)) begin
          // Partial window is dropped; any pending result stays untouched.
          state_d    = StIdle;
          isi_cnt_d  = '0;
          last_isi_d = '0;
          seen_d     = 1'b0;
        end else begin
          cnt_d      = cnt_upd;
          sat_d      = sat_upd;
          isi_cnt_d  = isi_cnt_upd;
          last_isi_d = last_isi_upd;
          seen_d     = seen_upd;
          if (rem_q == RemOne) begin
            // Completed window: publish, then restart with no gap or stop.
            load = 1'b1;
            if (en) begin
              rem_d = win_len_eff;
              cnt_d = '0;
              sat_d = 1'b0;
            end else begin
              state_d    = StIdle;
              isi_cnt_d  = '0;
              last_isi_d = '0;
              seen_d     = 1'b0;
            end
          end else begin
            rem_d = rem_q - RemOne;
          end
        end
      end
    endcase
  end

  // Result register and handshake; a new result wins over a same-cycle transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_isi_d   = out_isi_q;
    out_sat_d   = out_sat_q;
    overrun_d   = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      out_count_d = cnt_upd;
      out_isi_d   = last_isi_upd;
      out_sat_d   = sat_upd;
      overrun_d   = out_valid_q & ~res.out_ready;
    end else if (out_valid_q && res.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and data registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      prev_q      <= 1'b0;
      rem_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      isi_cnt_q   <= '0;
      last_isi_q  <= '0;
      seen_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_isi_q   <= '0;
      out_sat_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= spike_in;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      isi_cnt_q   <= isi_cnt_d;
      last_isi_q  <= last_isi_d;
      seen_q      <= seen_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_isi_q   <= out_isi_d;
      out_sat_q   <= out_sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign res.out_valid = out_valid_q;
  assign res.out_count = out_count_q;
  assign res.out_isi   = out_isi_q;
  assign res.out_sat   = out_sat_q;
  assign res.overrun   = overrun_q;

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Reader side of the neuron spike interface: samples a 1-bit spike line, the LIF neuron's signal_out, and converts it to windowed rate and inter-spike-interval (ISI) measurements. Each window produces one result word, delivered over a valid/ready handshake to a host-side consumer. Typical uses are on-chip characterisation of the neuron and feeding a readout bus.

Parameters:
WINDOW_W, 16, width of window length and window down-counter
CNT_W, 8, width of per-window spike count (saturating)
ISI_W, 16, width of ISI counter and result (saturating)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset, asynchronous assert, active-high; clears all state
spike_in  input  1  spike line, synchronous to clk
en  input  1  measurement enable; low returns block to IDLE
window_len  input  WINDOW_W  window length in cycles, sampled at each window start; 0 treated as 1
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_count  output  CNT_W  spike events in completed window
out_isi  output  ISI_W  most recent ISI in cycles; 0 = fewer than two events since en rose
out_sat  output  1  count saturated in this window
overrun  output  1  one-cycle pulse: unaccepted result overwritten

Behaviour:
- Reset (rst=1, async): state=IDLE; prev_spike=0; all counters 0; out_valid, out_count, out_isi, out_sat, overrun = 0. Deassertion is released synchronously by the top level.
- Event detection: event = spike_in & ~prev_spike; prev_spike registers spike_in every cycle in all states. A multi-cycle high pulse counts as one event.
- A line already high at window start is not an event.
- States:
  - IDLE: if en=1, load rem=max(window_len,1), clear cnt and sat, then go to COUNT next cycle.
  - COUNT: one window cycle per clock.
- COUNT, per cycle:
  - On event: cnt+1, saturating at 2^CNT_W-1; set sat if the increment would exceed the max.
  - rem decrements each cycle.
- Window end, on the cycle with rem==1 (an event on that cycle is included):
  - Next cycle: out_count=cnt, out_sat=sat, out_isi=last_isi, out_valid=1.
  - If en=1, the next window starts with no gap: resample window_len, clear cnt and sat, stay in COUNT. Else go to IDLE.
- Window length N: results appear on cycles N+1, 2N+1, ... after the first COUNT cycle, i.e. exactly N counted cycles per window.
- ISI tracking while en=1, across window boundaries:
  - isi_cnt increments every cycle, saturating at 2^ISI_W-1.
  - On an event with a prior event seen: last_isi=isi_cnt+1, isi_cnt=0.
  - On the first event: isi_cnt=0 only.
  - ISI = cycle distance between consecutive rising edges.
- Leaving COUNT / entering IDLE clears isi_cnt, last_isi and the prior-event flag.
- en=0 during COUNT: partial window discarded, no result, IDLE next cycle. A pending out_valid and its data are retained.
- Handshake: transfer when out_valid & out_ready. out_valid falls the next cycle unless a new result loads in the same cycle; then it stays 1 with the new data and there is no overrun.
- Output data is stable while out_valid=1 and no transfer.
- Overrun: a new result arrives while out_valid=1 and out_ready=0. Data is overwritten with the newest result, overrun=1 for exactly that cycle, out_valid stays 1.
- Async reset mid-window: everything clears immediately, no result emitted.

Test Plan:
- Reset: assert rst mid-COUNT with out_valid=1 -> all outputs 0 combinationally after assert; IDLE after release; no result until en re-sampled.
- window_len=10, out_ready=1, 1-cycle spikes on window cycles 2,5,8 -> out_valid for one cycle at window cycle 11, out_count=3, out_isi=3, out_sat=0.
- spike_in held high 4 cycles plus a 1-cycle pulse on the final window cycle (window_len=10) -> out_count=2; next window starts with no gap and counts 0 for the held level.
- CNT_W=8, window_len=600, pulse every 2 cycles -> out_count=255, out_sat=1, out_isi=2.
- out_ready=0, windows of 5 with 1 then 2 spikes -> overrun pulses once at second result; out_count=2; then out_ready=1 -> transfer, out_valid low next cycle.
- en dropped at window cycle 4 of 10 -> no out_valid, IDLE, last_isi cleared; re-enable -> first result after full new window, out_isi=0 if only one spike.
